// File: rtl/hft_pkt_pkg.sv
// Shared types and constants for the host-to-net packet framer.
// Holds the FIFO entry layout, default timing limits and the framer state encoding.
package hft_pkt_pkg;

  localparam int ENTRY_W  = 77;
  localparam int DATA_LSB = 0;
  localparam int KEEP_LSB = 64;
  localparam int SOP_BIT  = 72;
  localparam int EOP_BIT  = 73;
  localparam int ERR_BIT  = 74;
  localparam int QID_LSB  = 75;

  localparam int DEF_IPG       = 3;
  localparam int DEF_MAX_BEATS = 190;

  typedef struct packed {
    logic [1:0]  qid;
    logic        err;
    logic        eop;
    logic        sop;
    logic [7:0]  keep;
    logic [63:0] data;
  } tx_entry_t;

  // Entry as held on chip; qid is reserved and never stored.
  typedef struct packed {
    logic        err;
    logic        eop;
    logic        sop;
    logic [7:0]  keep;
    logic [63:0] data;
  } tx_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DROP = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_skid_buffer.sv
// Two-entry holding buffer between the FIFO read port and the framer FSM.
// Slot 0 is always the head; push and pop may happen in the same cycle.
module tx_skid_buffer
  import hft_pkt_pkg::*;
(
  input  logic       clk_net,
  input  logic       rst_n,
  input  logic       push,
  input  tx_beat_t   push_beat,
  input  logic       pop,
  output tx_beat_t   head,
  output logic [1:0] count
);

  tx_beat_t slot0;
  tx_beat_t slot1;

  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_beat;
          else               slot1 <= push_beat;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_beat;
          end else begin
            slot0 <= slot1;
            slot1 <= push_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/tx_packet_framer.sv
// Frames host-to-net FIFO entries onto a 64-bit MAC stream with abort,
// length-limit truncation and inter-packet gap enforcement.
//
// state | meaning
// IDLE  | waiting for a sop head entry; orphan (sop=0) entries are discarded
// SEND  | mid-packet, one entry per accepted beat
// GAP   | tvalid held low for IPG cycles after a packet ends
// DROP  | discarding the tail of an over-length packet
module tx_packet_framer
  import hft_pkt_pkg::*;
#(
  parameter int WIDTH     = ENTRY_W,
  parameter int IPG       = DEF_IPG,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic             clk_net,
  input  logic             rst_n,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [63:0]      tx_tdata,
  output logic [7:0]       tx_tkeep,
  output logic             tx_tlast,
  output logic             tx_tuser,
  output logic             tx_tvalid,
  input  logic             tx_tready,
  output logic [31:0]      pkt_count,
  output logic [15:0]      drop_count
);

  localparam logic [7:0] LIMIT_CNT = 8'(MAX_BEATS - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(IPG - 1);

  tx_state_t  state;
  tx_state_t  next_state;
  logic       rd_en_q;
  tx_beat_t   push_beat;
  tx_beat_t   head;
  logic [1:0] buf_count;
  logic       buf_pop;
  logic       head_valid;
  logic [2:0] occ;
  logic [7:0] beat_cnt;
  logic       err_acc;
  logic [3:0] gap_cnt;
  logic       at_limit;
  logic       accept;
  logic       synth;
  logic       trunc;
  logic       discard;
  logic       pkt_inc;
  logic       drop_inc;
  logic       unused_qid;

  assign push_beat = '{err:  fifo_dout[ERR_BIT],
                       eop:  fifo_dout[EOP_BIT],
                       sop:  fifo_dout[SOP_BIT],
                       keep: fifo_dout[KEEP_LSB +: 8],
                       data: fifo_dout[DATA_LSB +: 64]};
  assign unused_qid = ^fifo_dout[WIDTH-1:QID_LSB];

  tx_skid_buffer u_skid (
    .clk_net   (clk_net),
    .rst_n     (rst_n),
    .push      (rd_en_q),
    .push_beat (push_beat),
    .pop       (buf_pop),
    .head      (head),
    .count     (buf_count)
  );

  // A pop already issued but not yet captured still owns a slot; a pop out
  // of the buffer this cycle frees one, which keeps the path at 1 beat/cycle.
  assign head_valid = (buf_count != 2'd0);
  assign occ        = {1'b0, buf_count} + {2'b00, rd_en_q} - {2'b00, buf_pop};
  assign fifo_rd_en = rst_n && !fifo_empty && (occ < 3'd2);

  always_ff @(posedge clk_net) begin
    if (!rst_n) rd_en_q <= 1'b0;
    else        rd_en_q <= fifo_rd_en;
  end

  always_ff @(posedge clk_net) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  assign at_limit = (state == ST_IDLE) ? (MAX_BEATS == 1) : (beat_cnt == LIMIT_CNT);

  always_comb begin
    tx_tvalid = 1'b0;
    tx_tdata  = '0;
    tx_tkeep  = '0;
    tx_tlast  = 1'b0;
    tx_tuser  = 1'b0;
    synth     = 1'b0;
    trunc     = 1'b0;
    discard   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (head_valid) begin
          if (head.sop) begin
            tx_tvalid = 1'b1;
            tx_tdata  = head.data;
            tx_tkeep  = head.keep;
            trunc     = at_limit && !head.eop;
            tx_tlast  = head.eop || trunc;
            tx_tuser  = head.err || trunc;
          end else begin
            discard = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (head_valid) begin
          tx_tvalid = 1'b1;
          if (head.sop) begin
            synth    = 1'b1;
            tx_tlast = 1'b1;
            tx_tuser = 1'b1;
          end else begin
            tx_tdata = head.data;
            tx_tkeep = head.keep;
            trunc    = at_limit && !head.eop;
            tx_tlast = head.eop || trunc;
            tx_tuser = err_acc || head.err || trunc;
          end
        end
      end
      ST_DROP: discard = head_valid && !head.sop;
      default: ;
    endcase
  end

  assign accept  = tx_tvalid && tx_tready;
  assign buf_pop = discard || (accept && !synth);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (head.eop)  next_state = ST_GAP;
          else if (trunc) next_state = ST_DROP;
          else           next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (synth || head.eop) next_state = ST_GAP;
          else if (trunc)        next_state = ST_DROP;
        end
      end
      ST_DROP: if (head_valid && (head.sop || head.eop)) next_state = ST_GAP;
      ST_GAP:  if (gap_cnt == 4'd0) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      gap_cnt <= 4'd0;
    end else if (state != ST_GAP && next_state == ST_GAP) begin
      gap_cnt <= GAP_LOAD;
    end else if (state == ST_GAP && gap_cnt != 4'd0) begin
      gap_cnt <= gap_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      beat_cnt <= 8'd0;
      err_acc  <= 1'b0;
    end else if (accept && !synth) begin
      if (state == ST_IDLE) begin
        beat_cnt <= 8'd1;
        err_acc  <= head.err;
      end else begin
        beat_cnt <= beat_cnt + 8'd1;
        err_acc  <= err_acc | head.err;
      end
    end
  end

  assign pkt_inc  = accept && !synth && head.eop;
  assign drop_inc = (discard && state == ST_IDLE) || (accept && (synth || trunc));

  always_ff @(posedge clk_net) begin
    if (!rst_n) begin
      pkt_count  <= 32'd0;
      drop_count <= 16'd0;
    end else begin
      if (pkt_inc && pkt_count != '1)   pkt_count  <= pkt_count + 32'd1;
      if (drop_inc && drop_count != '1) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tx_packet_framer.sv
// Randomized bench for tx_packet_framer against a packet-level stream model.
module tb_tx_packet_framer;

  localparam int IPG  = 3;
  localparam int MAXB = 190;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic        clk_net = 1'b0;
  logic        rst_n = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [76:0] fifo_dout = '0;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast;
  logic        tx_tuser;
  logic        tx_tvalid;
  logic        tx_tready = 1'b1;
  logic [31:0] pkt_count;
  logic [15:0] drop_count;

  tx_packet_framer #(.WIDTH(77), .IPG(IPG), .MAX_BEATS(MAXB)) dut (
    .clk_net(clk_net), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tlast(tx_tlast),
    .tx_tuser(tx_tuser), .tx_tvalid(tx_tvalid), .tx_tready(tx_tready),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always #5 clk_net = ~clk_net;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_net) cyc <= cyc + 1;

  // FIFO model: popped entry appears on fifo_dout one cycle later.
  logic [76:0] fifo_mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_viol = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk_net) begin
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) rd_viol <= rd_viol + 1;
      else begin
        fifo_dout <= fifo_mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  int rdy_mode = 0;
  int rdy_phase = 0;
  always @(posedge clk_net) begin
    #1;
    case (rdy_mode)
      0: tx_tready = 1'b1;
      1: begin tx_tready = (rdy_phase % 3 == 0); rdy_phase++; end
      default: tx_tready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Stream monitor, sampled mid-cycle.
  beat_t obs_q[$];
  int    obs_cyc[$];
  int    stall_viol = 0;
  int    gap_viol = 0;
  int    last_end = -100;
  logic  p_stall = 1'b0;
  beat_t p_beat;
  beat_t mon_b;
  always @(negedge clk_net) begin
    if (!rst_n) begin
      p_stall  = 1'b0;
      last_end = -100;
    end else begin
      mon_b = '{tx_tdata, tx_tkeep, tx_tlast, tx_tuser};
      if (p_stall && (!tx_tvalid || mon_b !== p_beat)) stall_viol++;
      if (tx_tvalid && cyc != last_end && (cyc - last_end) <= IPG) gap_viol++;
      if (tx_tvalid && tx_tready) begin
        obs_q.push_back(mon_b);
        obs_cyc.push_back(cyc);
        if (tx_tlast) last_end = cyc;
      end
      p_stall = tx_tvalid && !tx_tready;
      p_beat  = mon_b;
    end
  end

  // Reference model: walks the entry stream packet by packet.
  beat_t exp_q[$];
  bit m_inpkt = 0;
  bit m_dropping = 0;
  int m_n = 0;
  bit m_err = 0;
  int m_pkt = 0;
  int m_drop = 0;

  task automatic model_entry(input logic [76:0] e);
    bit again;
    bit sop, eop, err;
    sop = e[72]; eop = e[73]; err = e[74];
    again = 1;
    while (again) begin
      again = 0;
      if (m_dropping) begin
        if (sop) begin m_dropping = 0; again = 1; end
        else if (eop) m_dropping = 0;
      end else if (m_inpkt && sop) begin
        exp_q.push_back('{64'd0, 8'd0, 1'b1, 1'b1});
        m_drop++;
        m_inpkt = 0;
        again = 1;
      end else if (!m_inpkt && !sop) begin
        m_drop++;
      end else begin
        m_n   = sop ? 1 : m_n + 1;
        m_err = sop ? err : (m_err | err);
        if (eop) begin
          exp_q.push_back('{e[63:0], e[71:64], 1'b1, m_err});
          m_pkt++;
          m_inpkt = 0;
        end else if (m_n == MAXB) begin
          exp_q.push_back('{e[63:0], e[71:64], 1'b1, 1'b1});
          m_drop++;
          m_inpkt = 0;
          m_dropping = 1;
        end else begin
          exp_q.push_back('{e[63:0], e[71:64], 1'b0, m_err});
          m_inpkt = 1;
        end
      end
    end
  endtask

  function automatic logic [76:0] mk(input logic sop, input logic eop, input logic err,
                                     input logic [7:0] keep, input logic [63:0] data);
    logic [1:0] q;
    q = 2'($urandom_range(0, 3));
    return {q, err, eop, sop, keep, data};
  endfunction

  task automatic push_entry(input logic [76:0] e);
    fifo_mem[wr_ptr] = e;
    wr_ptr++;
    model_entry(e);
  endtask

  task automatic start_test();
    obs_q.delete();
    obs_cyc.delete();
    exp_q.delete();
  endtask

  task automatic drain(output bit timeout);
    int n;
    n = 0;
    while ((obs_q.size() < exp_q.size() || rd_ptr != wr_ptr) && n < 5000) begin
      @(posedge clk_net);
      n++;
    end
    repeat (IPG + 8) @(posedge clk_net);
    #1;
    timeout = (n >= 5000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_net);
    #1;
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tuser, fifo_rd_en} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {tx_tvalid, tx_tlast, tx_tuser, fifo_rd_en});
    end
    checks++;
    if ({tx_tdata, tx_tkeep} !== 72'd0) begin
      errors++; $display("FAIL reset_data got %h want 0", {tx_tdata, tx_tkeep});
    end
    checks++;
    if (pkt_count !== 32'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", pkt_count, drop_count);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk_net);
    #1;
  endtask

  task automatic test_basic();
    bit to;
    logic [7:0] keeps [3];
    keeps[0] = 8'hFF; keeps[1] = 8'hFF; keeps[2] = 8'h0F;
    start_test();
    rdy_mode = 0;
    for (int p = 0; p < 2; p++)
      for (int b = 0; b < 3; b++)
        push_entry(mk(b == 0, b == 2, 1'b0, keeps[b], {$urandom, $urandom}));
    drain(to);
    checks++;
    if (to || obs_q.size() != 6) begin
      errors++; $display("FAIL basic_beats got %0d want 6 (timeout %0d)", obs_q.size(), to);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() == 6) begin
      checks++;
      if (obs_q[2].last !== 1'b1 || obs_q[2].user !== 1'b0 || obs_q[2].keep !== 8'h0F || obs_q[1].last !== 1'b0) begin
        errors++; $display("FAIL basic_last got last=%b user=%b keep=%h want 1 0 0f", obs_q[2].last, obs_q[2].user, obs_q[2].keep);
      end
      checks++;
      if (obs_cyc[1] - obs_cyc[0] != 1 || obs_cyc[2] - obs_cyc[1] != 1) begin
        errors++; $display("FAIL basic_rate got spacing %0d,%0d want 1,1", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
      end
      checks++;
      if (obs_cyc[3] - obs_cyc[2] != IPG + 1) begin
        errors++; $display("FAIL basic_ipg got %0d want %0d", obs_cyc[3] - obs_cyc[2], IPG + 1);
      end
    end
    checks++;
    if (pkt_count !== 32'(m_pkt) || m_pkt != 2) begin
      errors++; $display("FAIL basic_pkt got %0d want %0d", pkt_count, m_pkt);
    end
  endtask

  task automatic test_stall();
    bit to;
    start_test();
    rdy_mode = 1;
    rdy_phase = 0;
    push_entry(mk(1'b1, 1'b0, 1'b0, 8'hFF, {$urandom, $urandom}));
    push_entry(mk(1'b0, 1'b0, 1'b0, 8'hFF, {$urandom, $urandom}));
    push_entry(mk(1'b0, 1'b1, 1'b0, 8'h0F, {$urandom, $urandom}));
    drain(to);
    checks++;
    if (to || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stall_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stall_viol != 0) begin
      errors++; $display("FAIL stall_hold got %0d violations want 0", stall_viol);
    end
    checks++;
    if (pkt_count !== 32'(m_pkt)) begin
      errors++; $display("FAIL stall_pkt got %0d want %0d", pkt_count, m_pkt);
    end
  endtask

  task automatic test_missing_eop();
    bit to;
    int d0;
    start_test();
    rdy_mode = 0;
    d0 = m_drop;
    push_entry(mk(1'b1, 1'b0, 1'b0, 8'hFF, {$urandom, $urandom}));
    push_entry(mk(1'b0, 1'b0, 1'b0, 8'hFF, {$urandom, $urandom}));
    push_entry(mk(1'b1, 1'b0, 1'b0, 8'hFF, {$urandom, $urandom}));
    push_entry(mk(1'b0, 1'b1, 1'b0, 8'h03, {$urandom, $urandom}));
    drain(to);
    checks++;
    if (to || obs_q.size() != 5) begin
      errors++; $display("FAIL abort_beats got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL abort_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 3) begin
      checks++;
      if (obs_q[2].keep !== 8'h00 || obs_q[2].last !== 1'b1 || obs_q[2].user !== 1'b1) begin
        errors++; $display("FAIL abort_synth got keep=%h last=%b user=%b want 00 1 1", obs_q[2].keep, obs_q[2].last, obs_q[2].user);
      end
    end
    checks++;
    if (drop_count !== 16'(d0 + 1)) begin
      errors++; $display("FAIL abort_drop got %0d want %0d", drop_count, d0 + 1);
    end
    checks++;
    if (pkt_count !== 32'(m_pkt)) begin
      errors++; $display("FAIL abort_pkt got %0d want %0d", pkt_count, m_pkt);
    end
  endtask

  task automatic test_truncate();
    bit to;
    int d0, p0;
    start_test();
    rdy_mode = 0;
    d0 = m_drop;
    p0 = m_pkt;
    for (int b = 0; b < 192; b++)
      push_entry(mk(b == 0, b == 191, 1'b0, 8'hFF, {$urandom, $urandom}));
    drain(to);
    checks++;
    if (to || obs_q.size() != MAXB) begin
      errors++; $display("FAIL trunc_beats got %0d want %0d", obs_q.size(), MAXB);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL trunc_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= MAXB) begin
      checks++;
      if (obs_q[MAXB-1].last !== 1'b1 || obs_q[MAXB-1].user !== 1'b1) begin
        errors++; $display("FAIL trunc_last got last=%b user=%b want 1 1", obs_q[MAXB-1].last, obs_q[MAXB-1].user);
      end
    end
    checks++;
    if (drop_count !== 16'(d0 + 1) || pkt_count !== 32'(p0)) begin
      errors++; $display("FAIL trunc_counts got %0d/%0d want %0d/%0d", pkt_count, drop_count, p0, d0 + 1);
    end
  endtask

  task automatic test_orphan_err();
    bit to;
    int d0, p0;
    start_test();
    rdy_mode = 0;
    d0 = m_drop;
    p0 = m_pkt;
    push_entry(mk(1'b0, 1'b1, 1'b0, 8'hFF, {$urandom, $urandom}));
    push_entry(mk(1'b1, 1'b1, 1'b1, 8'h7F, {$urandom, $urandom}));
    drain(to);
    checks++;
    if (to || obs_q.size() != 1) begin
      errors++; $display("FAIL orphan_beats got %0d want 1", obs_q.size());
    end
    if (obs_q.size() >= 1 && exp_q.size() >= 1) begin
      checks++;
      if (obs_q[0] !== exp_q[0] || obs_q[0].last !== 1'b1 || obs_q[0].user !== 1'b1) begin
        errors++; $display("FAIL orphan_beat got %h want %h", obs_q[0], exp_q[0]);
      end
    end
    checks++;
    if (drop_count !== 16'(d0 + 1) || pkt_count !== 32'(p0 + 1)) begin
      errors++; $display("FAIL orphan_counts got %0d/%0d want %0d/%0d", pkt_count, drop_count, p0 + 1, d0 + 1);
    end
  endtask

  task automatic test_reset_mid_send();
    bit to;
    int n;
    start_test();
    rdy_mode = 0;
    for (int b = 0; b < 5; b++)
      push_entry(mk(b == 0, 1'b0, 1'b0, 8'hFF, {$urandom, $urandom}));
    n = 0;
    while (obs_q.size() < 5 && n < 2000) begin @(posedge clk_net); n++; end
    checks++;
    if (n >= 2000) begin
      errors++; $display("FAIL rst_mid_wait got %0d beats want 5", obs_q.size());
    end
    repeat (2) @(posedge clk_net);
    #1 rst_n = 1'b0;
    @(posedge clk_net);
    #1;
    checks++;
    if ({tx_tvalid, tx_tlast, tx_tuser, fifo_rd_en, tx_tdata, tx_tkeep} !== 76'd0) begin
      errors++; $display("FAIL rst_mid_outputs got %h want 0", {tx_tvalid, tx_tlast, tx_tuser, fifo_rd_en, tx_tdata, tx_tkeep});
    end
    checks++;
    if (pkt_count !== 32'd0 || drop_count !== 16'd0) begin
      errors++; $display("FAIL rst_mid_counts got %0d/%0d want 0/0", pkt_count, drop_count);
    end
    rst_n = 1'b1;
    m_inpkt = 0; m_dropping = 0; m_pkt = 0; m_drop = 0;
    start_test();
    @(posedge clk_net);
    #1;
    for (int b = 0; b < 3; b++)
      push_entry(mk(b == 0, b == 2, 1'b0, 8'hFF, {$urandom, $urandom}));
    drain(to);
    checks++;
    if (to || obs_q.size() != 3) begin
      errors++; $display("FAIL rst_mid_beats got %0d want 3", obs_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rst_mid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt_count !== 32'd1 || drop_count !== 16'd0) begin
      errors++; $display("FAIL rst_mid_after got %0d/%0d want 1/0", pkt_count, drop_count);
    end
  endtask

  task automatic test_random();
    bit to;
    int kind, len;
    start_test();
    rdy_mode = 2;
    for (int p = 0; p < 30; p++) begin
      kind = (p == 29) ? 0 : $urandom_range(0, 9);
      len  = $urandom_range(1, 6);
      if (kind <= 6) begin
        for (int b = 0; b < len; b++)
          push_entry(mk(b == 0, b == len - 1, $urandom_range(0, 7) == 0, 8'($urandom), {$urandom, $urandom}));
      end else if (kind <= 8) begin
        for (int b = 0; b < len; b++)
          push_entry(mk(b == 0, 1'b0, $urandom_range(0, 7) == 0, 8'($urandom), {$urandom, $urandom}));
      end else begin
        push_entry(mk(1'b0, $urandom_range(0, 1) == 1, 1'b0, 8'($urandom), {$urandom, $urandom}));
      end
    end
    drain(to);
    checks++;
    if (to || obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_beats got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pkt_count !== 32'(m_pkt) || drop_count !== 16'(m_drop)) begin
      errors++; $display("FAIL rand_counts got %0d/%0d want %0d/%0d", pkt_count, drop_count, m_pkt, m_drop);
    end
    checks++;
    if (stall_viol != 0 || gap_viol != 0 || rd_viol != 0) begin
      errors++; $display("FAIL rand_protocol got stall=%0d gap=%0d underflow=%0d want 0", stall_viol, gap_viol, rd_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_missing_eop();
    test_truncate();
    test_orphan_err();
    test_reset_mid_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_packet_framer.md
TX_PACKET_FRAMER -- requirements
Module: tx_packet_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 77, meaning the FIFO entry width.
REQ-002 SHALL have parameter IPG, default 3, meaning the idle cycles after each packet; legal range 1..15.
REQ-003 SHALL have parameter MAX_BEATS, default 190, meaning the longest legal packet in 8-byte beats.
REQ-004 SHALL have port clk_net  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port fifo_empty  in  1  host-to-net FIFO is empty.
REQ-007 SHALL have port fifo_rd_en  out  1  FIFO pop; the popped entry appears on fifo_dout on the next cycle.
REQ-008 SHALL have port fifo_dout  in  WIDTH  entry {qid[1:0], err, eop, sop, keep[7:0], data[63:0]}, bits 76..0.
REQ-009 SHALL have ports tx_tdata  out  64, tx_tkeep  out  8, tx_tlast  out  1, tx_tuser  out  1 (abort/error); these form the MAC stream.
REQ-010 SHALL have ports tx_tvalid  out  1 and tx_tready  in  1, the valid/ready handshake.
REQ-011 SHALL have ports pkt_count  out  32 (packets completed) and drop_count  out  16 (packets dropped or aborted).

Function
REQ-012 SHALL drive fifo_rd_en = !fifo_empty and a free slot in the 2-entry holding buffer, counting an in-flight pop as an occupied slot.
REQ-013 SHALL capture fifo_dout into the holding buffer on the cycle after fifo_rd_en; tx_tvalid may first assert on the following cycle (pop at N, tvalid at N+2).
REQ-014 SHALL sustain 1 beat/cycle while tx_tready=1 and the FIFO is non-empty.
REQ-015 SHALL hold tx_tdata, tx_tkeep, tx_tlast and tx_tuser stable, and keep tx_tvalid high, while tx_tvalid=1 and tx_tready=0.
REQ-016 SHALL implement the states IDLE, SEND, GAP and DROP.
REQ-017 In IDLE, SHALL present a head entry with sop=1 as its first beat and enter SEND when that beat is accepted; a head entry with sop=0 SHALL be discarded without presenting it and increment drop_count.
REQ-018 A single-beat packet (sop=1, eop=1) SHALL go from IDLE straight to GAP.
REQ-019 In SEND, SHALL pop one entry per accepted beat, drive tx_tlast = eop, and drive tx_tuser = OR of err over all beats of the packet, including the current beat.
REQ-020 On acceptance of an eop beat, SHALL increment pkt_count (err packets included) and enter GAP.
REQ-021 In SEND, a head entry with sop=1 SHALL NOT be consumed; instead SHALL emit a synthetic beat with tkeep=0, tlast=1, tuser=1, increment drop_count, enter GAP, and then send the held entry as a new packet.
REQ-022 When beat MAX_BEATS is accepted without eop, SHALL send that beat with tlast=1, tuser=1, increment drop_count, and enter DROP.
REQ-023 In DROP, SHALL discard entries with tx_tvalid=0 up to and including the next eop, then enter GAP; a sop=1 entry in DROP SHALL end DROP without being consumed.
REQ-024 In GAP, SHALL hold tx_tvalid=0 for exactly IPG cycles, then enter IDLE.
REQ-025 SHALL saturate pkt_count at 2^32-1 and drop_count at 2^16-1.
REQ-026 SHALL use an 8-bit beat counter, cleared on each sop.
REQ-027 SHALL pass qid through to no output; it is reserved.

Reset
REQ-028 With rst_n=0 at a clock edge, SHALL set state=IDLE, empty the holding buffer, discard any in-flight pop, and clear fifo_rd_en, tx_tvalid, tx_tlast, tx_tuser, tx_tdata, tx_tkeep, pkt_count and drop_count to 0.
REQ-029 Reset during SEND SHALL produce no abort beat; the first beat after reset SHALL be a sop beat.

Structure
REQ-030 Package hft_pkt_pkg SHALL hold the tx_entry_t packed struct, the field bit positions, the default IPG and MAX_BEATS values, and the state enum.
REQ-031 The 2-entry holding buffer SHALL be a sub-module named tx_skid_buffer.

Verification
REQ-032 3-beat packet (sop on beat 0, eop on beat 2, keep=FF,FF,0F), tready=1 -> three consecutive tvalid beats with tlast on beat 3, tuser=0, pkt_count=1, 3 idle cycles before the next sop.
REQ-033 Same packet with tready toggling 1,0,0,1... -> outputs stable during stalls, no beat lost or duplicated.
REQ-034 sop, data, then sop (eop missing) -> synthetic beat with tkeep=00, tlast=1, tuser=1; drop_count=1; second packet then sent intact.
REQ-035 192-beat packet with MAX_BEATS=190 -> beat 190 has tlast=1, tuser=1; beats 191-192 discarded; drop_count=1; pkt_count unchanged.
REQ-036 Orphan beat (sop=0) followed by a good 1-beat packet with err=1 -> orphan dropped, drop_count=1; good beat sent with tlast=1, tuser=1; pkt_count=1.
REQ-037 rst_n=0 for 1 cycle mid-SEND -> all outputs 0 next cycle; next packet sent cleanly from its sop.
